// File: rtl/probe_trace_capture_if.sv
// Readout stream of the probe trace capture block: valid/ready handshake
// carrying one captured sample (all channels) per transfer.
interface probe_trace_capture_if #(
    parameter int DW = 256
);
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;

    modport master (
        output rd_valid,
        output rd_data,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/probe_trace_capture.sv
// Probe trace capture: records NUM_CH probe channels into a circular buffer,
// stops a programmable number of samples after a masked-compare trigger and
// then replays the retained window oldest-first over the readout stream.
module probe_trace_capture #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 64,
    parameter int DEPTH  = 16,
    parameter int IW     = $clog2(DEPTH),
    parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [NUM_CH*CH_W-1:0]   probe_data,
    input  logic                     sample_en,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [CW-1:0]            trig_ch,
    input  logic [CH_W-1:0]          trig_value,
    input  logic [CH_W-1:0]          trig_mask,
    input  logic [IW:0]              post_count,
    output logic [1:0]               state,
    probe_trace_capture_if.master    rd,
    output logic [IW-1:0]            trig_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DUMP  = 2'd3
    } state_t;

    localparam logic [IW:0]   FULL_W   = (IW+1)'(DEPTH);
    localparam logic [IW:0]   ONE_W    = (IW+1)'(1);
    localparam logic [IW:0]   TWO_W    = (IW+1)'(2);
    localparam logic [IW-1:0] ONE_I    = IW'(1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    // Registered state
    state_t                  state_r;
    logic [CW-1:0]           trig_ch_r;
    logic [CH_W-1:0]         trig_value_r;
    logic [CH_W-1:0]         trig_mask_r;
    logic [IW-1:0]           post_cnt_r;
    logic [IW-1:0]           wr_ptr_r;
    logic [IW:0]             fill_r;
    logic [IW-1:0]           post_rem_r;
    logic [IW-1:0]           rd_ptr_r;
    logic [IW:0]             rd_rem_r;
    logic [IW-1:0]           trig_idx_r;
    logic                    rd_valid_r;
    logic                    rd_last_r;
    logic [NUM_CH*CH_W-1:0]  mem_r [DEPTH];

    // Next-state values
    state_t                  state_nxt_s;
    logic [CW-1:0]           trig_ch_nxt_s;
    logic [CH_W-1:0]         trig_value_nxt_s;
    logic [CH_W-1:0]         trig_mask_nxt_s;
    logic [IW-1:0]           post_cnt_nxt_s;
    logic [IW-1:0]           wr_ptr_nxt_s;
    logic [IW:0]             fill_nxt_s;
    logic [IW-1:0]           post_rem_nxt_s;
    logic [IW-1:0]           rd_ptr_nxt_s;
    logic [IW:0]             rd_rem_nxt_s;
    logic [IW-1:0]           trig_idx_nxt_s;
    logic                    rd_valid_nxt_s;
    logic                    rd_last_nxt_s;

    // Helpers
    logic [CH_W-1:0]         ch_s [2**CW];
    logic [CH_W-1:0]         sel_ch_s;
    logic                    match_s;
    logic                    wr_en_s;
    logic [IW-1:0]           wr_ptr_inc_s;
    logic [IW:0]             fill_inc_s;
    logic [IW-1:0]           post_clamp_s;
    logic [IW-1:0]           dump_ptr_s;
    logic [IW-1:0]           dump_idx_s;
    logic                    dump_last_s;

    // Unused channel-select codes (NUM_CH not a power of 2) read as zero.
    for (genvar g = 0; g < 2**CW; g++) begin : g_ch
        if (g < NUM_CH) begin : g_real
            assign ch_s[g] = probe_data[g*CH_W +: CH_W];
        end else begin : g_pad
            assign ch_s[g] = '0;
        end
    end

    assign sel_ch_s     = ch_s[trig_ch_r];
    assign match_s      = sample_en && (((sel_ch_s ^ trig_value_r) & trig_mask_r) == '0);
    assign wr_en_s      = sample_en && !abort && ((state_r == ST_ARMED) || (state_r == ST_POST));
    assign wr_ptr_inc_s = wr_ptr_r + ONE_I;
    assign fill_inc_s   = (fill_r == FULL_W) ? fill_r : (fill_r + ONE_W);
    // Clamp so the trigger sample itself can never be overwritten.
    assign post_clamp_s = (post_count > {1'b0, LAST_IDX}) ? LAST_IDX : post_count[IW-1:0];
    // Values loaded on the edge that ends capture (fill already counts that sample).
    assign dump_ptr_s   = (fill_inc_s == FULL_W) ? wr_ptr_inc_s : '0;
    assign dump_idx_s   = fill_inc_s[IW-1:0] - ONE_I - post_cnt_r;
    assign dump_last_s  = (fill_inc_s == ONE_W);

    // Next-state and counter logic for the capture/replay FSM
    always_comb begin
        state_nxt_s      = state_r;
        trig_ch_nxt_s    = trig_ch_r;
        trig_value_nxt_s = trig_value_r;
        trig_mask_nxt_s  = trig_mask_r;
        post_cnt_nxt_s   = post_cnt_r;
        wr_ptr_nxt_s     = wr_ptr_r;
        fill_nxt_s       = fill_r;
        post_rem_nxt_s   = post_rem_r;
        rd_ptr_nxt_s     = rd_ptr_r;
        rd_rem_nxt_s     = rd_rem_r;
        trig_idx_nxt_s   = trig_idx_r;
        rd_valid_nxt_s   = rd_valid_r;
        rd_last_nxt_s    = rd_last_r;

        if (abort) begin
            state_nxt_s    = ST_IDLE;
            rd_valid_nxt_s = 1'b0;
            rd_last_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm) begin
                        state_nxt_s      = ST_ARMED;
                        trig_ch_nxt_s    = trig_ch;
                        trig_value_nxt_s = trig_value;
                        trig_mask_nxt_s  = trig_mask;
                        post_cnt_nxt_s   = post_clamp_s;
                        wr_ptr_nxt_s     = '0;
                        fill_nxt_s       = '0;
                        post_rem_nxt_s   = '0;
                        rd_ptr_nxt_s     = '0;
                        rd_rem_nxt_s     = '0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (sample_en) begin
                        wr_ptr_nxt_s = wr_ptr_inc_s;
                        fill_nxt_s   = fill_inc_s;
                        if (match_s) begin
                            post_rem_nxt_s = post_cnt_r;
                            if (post_cnt_r == '0) begin
                                state_nxt_s    = ST_DUMP;
                                rd_ptr_nxt_s   = dump_ptr_s;
                                rd_rem_nxt_s   = fill_inc_s;
                                trig_idx_nxt_s = dump_idx_s;
                                rd_valid_nxt_s = 1'b1;
                                rd_last_nxt_s  = dump_last_s;
                            end else begin
                                state_nxt_s = ST_POST;
                            end
                        end else begin
                            state_nxt_s = ST_ARMED;
                        end
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_POST: begin
                    if (sample_en) begin
                        wr_ptr_nxt_s   = wr_ptr_inc_s;
                        fill_nxt_s     = fill_inc_s;
                        post_rem_nxt_s = post_rem_r - ONE_I;
                        if (post_rem_r == ONE_I) begin
                            state_nxt_s    = ST_DUMP;
                            rd_ptr_nxt_s   = dump_ptr_s;
                            rd_rem_nxt_s   = fill_inc_s;
                            trig_idx_nxt_s = dump_idx_s;
                            rd_valid_nxt_s = 1'b1;
                            rd_last_nxt_s  = dump_last_s;
                        end else begin
                            state_nxt_s = ST_POST;
                        end
                    end else begin
                        state_nxt_s = ST_POST;
                    end
                end
                ST_DUMP: begin
                    if (rd_valid_r && rd.rd_ready) begin
                        rd_ptr_nxt_s = rd_ptr_r + ONE_I;
                        rd_rem_nxt_s = rd_rem_r - ONE_W;
                        if (rd_last_r) begin
                            state_nxt_s    = ST_IDLE;
                            rd_valid_nxt_s = 1'b0;
                            rd_last_nxt_s  = 1'b0;
                        end else begin
                            rd_last_nxt_s = (rd_rem_r == TWO_W);
                        end
                    end else begin
                        state_nxt_s = ST_DUMP;
                    end
                end
                default: begin
                    state_nxt_s    = ST_IDLE;
                    rd_valid_nxt_s = 1'b0;
                    rd_last_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // State, configuration and pointer registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= ST_IDLE;
            trig_ch_r    <= '0;
            trig_value_r <= '0;
            trig_mask_r  <= '0;
            post_cnt_r   <= '0;
            wr_ptr_r     <= '0;
            fill_r       <= '0;
            post_rem_r   <= '0;
            rd_ptr_r     <= '0;
            rd_rem_r     <= '0;
            trig_idx_r   <= '0;
            rd_valid_r   <= 1'b0;
            rd_last_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            trig_ch_r    <= trig_ch_nxt_s;
            trig_value_r <= trig_value_nxt_s;
            trig_mask_r  <= trig_mask_nxt_s;
            post_cnt_r   <= post_cnt_nxt_s;
            wr_ptr_r     <= wr_ptr_nxt_s;
            fill_r       <= fill_nxt_s;
            post_rem_r   <= post_rem_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            rd_rem_r     <= rd_rem_nxt_s;
            trig_idx_r   <= trig_idx_nxt_s;
            rd_valid_r   <= rd_valid_nxt_s;
            rd_last_r    <= rd_last_nxt_s;
        end
    end

    // Trace buffer write port; contents need no reset as nothing reads them unwritten
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= probe_data;
        end
    end

    assign state       = state_r;
    assign trig_idx    = trig_idx_r;
    assign rd.rd_valid = rd_valid_r;
    assign rd.rd_last  = rd_last_r;
    assign rd.rd_data  = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_probe_trace_capture.sv
// Directed self-checking bench for probe_trace_capture (4 x 64-bit, depth 16).
module tb_probe_trace_capture;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [255:0]  probe_data = '0;
    logic          sample_en = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    trig_ch = '0;
    logic [63:0]   trig_value = '0;
    logic [63:0]   trig_mask = '0;
    logic [4:0]    post_count = '0;
    logic [1:0]    state;
    logic [3:0]    trig_idx;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    probe_trace_capture_if #(.DW(256)) rd_if ();

    probe_trace_capture #(.NUM_CH(4), .CH_W(64), .DEPTH(16)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .probe_data (probe_data),
        .sample_en  (sample_en),
        .arm        (arm),
        .abort      (abort),
        .trig_ch    (trig_ch),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .post_count (post_count),
        .state      (state),
        .rd         (rd_if),
        .trig_idx   (trig_idx)
    );

    always #5 CLK = ~CLK;

    // Sample k: ch0 = k, ch1 = ~k, ch2 = 3k, ch3 = k ^ A5A5...
    function automatic logic [255:0] mk(input int k);
        logic [63:0] v;
        v = 64'(k);
        return {64'hA5A5_0000_0000_0000 ^ v, v * 64'd3, ~v, v};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic feed_one(input int v, input logic en);
        probe_data = mk(v);
        sample_en  = en;
        tick();
        sample_en  = 1'b0;
    endtask

    task automatic feed_seq(input int first, input int n);
        for (int i = 0; i < n; i++) feed_one(first + i, 1'b1);
    endtask

    task automatic set_seq(input int first, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(first + i);
    endtask

    task automatic arm_cfg(input logic [1:0] ch, input logic [63:0] val,
                           input logic [63:0] msk, input logic [4:0] post);
        trig_ch = ch; trig_value = val; trig_mask = msk; post_count = post;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_state", state, 2'd1);
    endtask

    // Consume readout; exp_q holds the expected ch0 sequence of n entries.
    task automatic drain(input int n, input int stop_after, input int pct, input int exp_trig);
        int i = 0;
        int budget = 0;
        logic rdy;
        chk("dump_state", state, 2'd3);
        chk("trig_idx", trig_idx, 256'(exp_trig));
        while (i < stop_after && budget < 500) begin
            rdy = ($urandom_range(0, 99) < pct);
            rd_if.rd_ready = rdy;
            chk("rd_valid", rd_if.rd_valid, 1'b1);
            chk("rd_data", rd_if.rd_data, mk(exp_q[i]));
            chk("rd_last", rd_if.rd_last, (i == n - 1));
            tick();
            if (rdy) i++;
            budget++;
        end
        rd_if.rd_ready = 1'b0;
        if (budget >= 500) begin
            n_tests++;
            n_fail++;
            $error("FAIL drain_timeout: got %0d transfers expected %0d", i, stop_after);
        end
        if (stop_after == n) begin
            chk("post_dump_valid", rd_if.rd_valid, 1'b0);
            chk("post_dump_state", state, 2'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_if.rd_ready = 1'b0;

        // 1. Reset
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_if.rd_ready = i[0];
            tick();
            chk("rst_state", state, 2'd0);
            chk("rst_valid", rd_if.rd_valid, 1'b0);
            chk("rst_last", rd_if.rd_last, 1'b0);
            chk("rst_trig_idx", trig_idx, 4'd0);
        end
        rd_if.rd_ready = 1'b0;

        // 2. Wrap case: trigger at 20, 5 post samples
        arm_cfg(2'd0, 64'd20, '1, 5'd5);
        feed_seq(0, 25);
        chk("wrap_post", state, 2'd2);
        feed_seq(25, 1);
        set_seq(10, 16);
        drain(16, 16, 100, 10);

        // 3a. Early trigger at 3, post 2
        arm_cfg(2'd0, 64'd3, '1, 5'd2);
        feed_seq(0, 5);
        chk("early_post", state, 2'd2);
        feed_seq(5, 1);
        set_seq(0, 6);
        drain(6, 6, 100, 3);

        // 3b. post_count 0: DUMP on the trigger edge
        arm_cfg(2'd0, 64'd7, '1, 5'd0);
        feed_seq(0, 7);
        chk("post0_armed", state, 2'd1);
        feed_seq(7, 1);
        set_seq(0, 8);
        drain(8, 8, 100, 7);

        // 3c. post_count 20 clamps to 15
        arm_cfg(2'd0, 64'd30, '1, 5'd20);
        feed_seq(0, 30);
        chk("clamp_armed", state, 2'd1);
        feed_seq(30, 15);
        chk("clamp_post", state, 2'd2);
        feed_seq(45, 1);
        set_seq(30, 16);
        drain(16, 16, 100, 0);

        // 4. Masked compare and sample_en gaps
        arm_cfg(2'd0, 64'h30, 64'hF0, 5'd1);
        feed_one(32'h2E, 1'b1);
        feed_one(32'h2F, 1'b1);
        feed_one(32'h35, 1'b0);
        chk("gap_no_trig", state, 2'd1);
        feed_one(32'h31, 1'b1);
        chk("mask_trig", state, 2'd2);
        feed_one(32'h32, 1'b1);
        exp_q.delete();
        exp_q.push_back(32'h2E);
        exp_q.push_back(32'h2F);
        exp_q.push_back(32'h31);
        exp_q.push_back(32'h32);
        drain(4, 4, 100, 2);

        // 5. Wrap case with 30% ready backpressure
        arm_cfg(2'd0, 64'd20, '1, 5'd5);
        feed_seq(0, 26);
        set_seq(10, 16);
        drain(16, 16, 30, 10);

        // 6a. Abort in POST
        arm_cfg(2'd0, 64'd5, '1, 5'd8);
        feed_seq(0, 7);
        chk("abort_pre", state, 2'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_state", state, 2'd0);
        chk("abort_valid", rd_if.rd_valid, 1'b0);

        // 6b. Reset after the 4th readout transfer
        arm_cfg(2'd0, 64'd20, '1, 5'd5);
        feed_seq(0, 26);
        set_seq(10, 16);
        drain(16, 4, 100, 10);
        RST_N = 1'b0;
        #1;
        chk("midrst_valid", rd_if.rd_valid, 1'b0);
        chk("midrst_state", state, 2'd0);
        chk("midrst_last", rd_if.rd_last, 1'b0);
        chk("midrst_trig_idx", trig_idx, 4'd0);
        #2;
        RST_N = 1'b1;
        tick();
        chk("after_rst_state", state, 2'd0);
        // Clean re-capture, trigger on channel 1 (= ~k) at k = 3
        arm_cfg(2'd1, ~64'd3, '1, 5'd2);
        feed_seq(0, 6);
        set_seq(0, 6);
        drain(6, 6, 100, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
